clock_period_meter: RTL and testbench

//   Measures a slow, divided clock (e.g. clock_divider.out_clk) against the system clock.

---
 rtl/clock_period_meter.sv | 137 +++++++++++++
 tb/tb_clock_period_meter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow, asynchronous clock in system-clock cycles.
// Both edges see the same synchronizer latency, so the differences between them are exact.
module clock_period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_clk,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   synced_s;
  logic                   rise_s;
  logic                   fall_s;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [WIDTH-1:0]       cnt_r;
  logic [WIDTH-1:0]       cnt_next_s;
  logic [WIDTH-1:0]       hcnt_r;
  logic [WIDTH-1:0]       hcnt_next_s;
  logic                   hi_run_r;
  logic                   hi_run_next_s;
  logic [WIDTH-1:0]       period_next_s;
  logic [WIDTH-1:0]       high_next_s;
  logic                   valid_next_s;
  logic                   timeout_next_s;

  // Synchronizer chain plus the previous-value flop used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_clk};
      prev_r <= synced_s;
    end
  end

  // A rise and a fall can never coincide: they need opposite values of synced_s.
  assign synced_s = sync_r[SYNC_STAGES-1];
  assign rise_s   = synced_s & ~prev_r;
  assign fall_s   = ~synced_s & prev_r;

  // Next-state and next-output logic for the arm/measure machine.
  always_comb begin
    next_state_s   = state_r;
    cnt_next_s     = cnt_r;
    hcnt_next_s    = hcnt_r;
    hi_run_next_s  = hi_run_r;
    period_next_s  = period;
    high_next_s    = high_time;
    valid_next_s   = 1'b0;
    timeout_next_s = timeout;

    case (state_r)
      ST_IDLE: begin
        // The first rise only arms; there is no earlier edge to measure from.
        if (rise_s) begin
          cnt_next_s    = CNT_ONE;
          hcnt_next_s   = CNT_ONE;
          hi_run_next_s = 1'b1;
          next_state_s  = ST_MEASURE;
        end else begin
          next_state_s  = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (rise_s) begin
          period_next_s  = cnt_r;
          high_next_s    = hcnt_r;
          valid_next_s   = 1'b1;
          timeout_next_s = 1'b0;
          cnt_next_s     = CNT_ONE;
          hcnt_next_s    = CNT_ONE;
          hi_run_next_s  = 1'b1;
        end else if (cnt_r == CNT_MAX) begin
          // Saturated without a rise: flag it and disarm rather than wrap.
          timeout_next_s = 1'b1;
          hi_run_next_s  = 1'b0;
          next_state_s   = ST_IDLE;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
          if (fall_s) begin
            hi_run_next_s = 1'b0;
          end else if (hi_run_r) begin
            hcnt_next_s = hcnt_r + CNT_ONE;
          end else begin
            hcnt_next_s = hcnt_r;
          end
        end
      end
      default: begin
        next_state_s  = ST_IDLE;
        hi_run_next_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      hcnt_r    <= '0;
      hi_run_r  <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_next_s;
      hcnt_r    <= hcnt_next_s;
      hi_run_r  <= hi_run_next_s;
      period    <= period_next_s;
      high_time <= high_next_s;
      valid     <= valid_next_s;
      timeout   <= timeout_next_s;
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: an edge-time model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_clock_period_meter;

  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int LAT  = SS;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_clk = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  always #5 clk = ~clk;

  clock_period_meter #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_clk    (in_clk),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic         v;
    logic         t;
  } snap_t;

  snap_t exp_q[$];
  snap_t cur;
  snap_t expd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 1'b0;
  bit prev_in = 1'b0;
  bit armed = 1'b0;
  bit seen_fall = 1'b0;
  int last_rise = 0;
  int last_fall = 0;
  int valid_cnt = 0;
  int last_valid_cyc = -1;
  int to_rise_cyc = -1;
  bit prev_to = 1'b0;
  int v0 = 0;
  int n = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model in terms of input edge times; outputs appear LAT cycles after the edge is sampled.
  task automatic model_step();
    bit r;
    bit f;
    if (reset) begin
      prev_in   = 1'b0;
      armed     = 1'b0;
      seen_fall = 1'b0;
      cur       = '0;
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back('0);
      expd      = '0;
      model_on  = 1'b1;
    end else begin
      r       = in_clk & ~prev_in;
      f       = ~in_clk & prev_in;
      prev_in = in_clk;
      cur.v   = 1'b0;
      if (r) begin
        if (armed) begin
          cur.p = W'(cyc - last_rise);
          cur.h = W'(seen_fall ? (last_fall - last_rise) : (cyc - last_rise));
          cur.v = 1'b1;
          cur.t = 1'b0;
        end
        armed     = 1'b1;
        last_rise = cyc;
        seen_fall = 1'b0;
      end else if (armed && (cyc - last_rise == MAXC)) begin
        cur.t = 1'b1;
        armed = 1'b0;
      end else if (f && armed) begin
        seen_fall = 1'b1;
        last_fall = cyc;
      end
      exp_q.push_back(cur);
      expd = exp_q.pop_front();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    model_step();
    if (model_on) begin
      check("period", period, expd.p);
      check("high_time", high_time, expd.h);
      check("valid", valid, expd.v);
      check("timeout", timeout, expd.t);
      if (valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
      if (timeout && !prev_to) to_rise_cyc = cyc;
      prev_to = timeout;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      in_clk = 1'b1;
      repeat (hi) tick();
      in_clk = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    // Reset state
    do_reset(3);
    tick();
    check("reset_period", period, 0);
    check("reset_high", high_time, 0);
    check("reset_valid", valid, 0);
    check("reset_timeout", timeout, 0);

    // 5 high / 5 low: six rises, the first only arms
    v0 = valid_cnt;
    wave(5, 5, 6);
    repeat (3) tick();
    check("t1_valids", valid_cnt - v0, 5);
    check("t1_period", period, 10);
    check("t1_high", high_time, 5);
    check("t1_model_period", expd.p, 10);

    // Fastest input: period 2, valid every other cycle
    do_reset(1);
    v0 = valid_cnt;
    wave(1, 1, 8);
    repeat (3) tick();
    check("t2_valids", valid_cnt - v0, 7);
    check("t2_period", period, 2);
    check("t2_high", high_time, 1);

    // 3 high / 7 low
    do_reset(1);
    v0 = valid_cnt;
    wave(3, 7, 6);
    repeat (3) tick();
    check("t3_valids", valid_cnt - v0, 5);
    check("t3_period", period, 10);
    check("t3_high", high_time, 3);
    check("t3_model_high", expd.h, 3);

    // Input stops low: timeout exactly MAXC cycles after the last measured rise
    n = 0;
    while (!timeout && n < 400) begin
      tick();
      n++;
    end
    check("t4_timeout_seen", timeout, 1);
    check("t4_timeout_gap", to_rise_cyc - last_valid_cyc, MAXC);
    check("t4_period_hold", period, 10);
    check("t4_high_hold", high_time, 3);
    v0 = valid_cnt;
    wave(3, 7, 1);
    check("t4_arm_no_valid", valid_cnt - v0, 0);
    check("t4_timeout_held", timeout, 1);
    wave(3, 7, 1);
    check("t4_restart_valid", valid_cnt - v0, 1);
    check("t4_timeout_clear", timeout, 0);
    check("t4_restart_period", period, 10);

    // Reset pulsed mid-period
    do_reset(1);
    wave(4, 6, 3);
    in_clk = 1'b1;
    repeat (4) tick();
    in_clk = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_period_zero", period, 0);
    check("t5_high_zero", high_time, 0);
    check("t5_valid_zero", valid, 0);
    v0 = valid_cnt;
    wave(4, 6, 1);
    check("t5_arm_no_valid", valid_cnt - v0, 0);
    wave(4, 6, 1);
    repeat (3) tick();
    check("t5_valid_after_2", valid_cnt - v0, 1);
    check("t5_period", period, 10);
    check("t5_high", high_time, 4);

    // in_clk held high through and after reset: arm only, then timeout
    in_clk = 1'b1;
    do_reset(3);
    v0 = valid_cnt;
    repeat (250) tick();
    check("t6_no_early_timeout", timeout, 0);
    repeat (20) tick();
    check("t6_timeout", timeout, 1);
    check("t6_no_valid", valid_cnt - v0, 0);
    check("t6_period", period, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
